audio_stream_bridge: RTL and testbench

Parametrised sample bridge between the I2S receive codec, an external per-sample processing engine (EQ/filter) and the I2S transmit codec. It tags each received sample with its channel and buffers it in a small FIFO toward the processing engine. Processed results are held in per-channel output slots until the transmitter requests them. Per-channel bypass at full resolution, underrun/overrun policy and saturating error counters replace the fixed single-channel latch-and-mux used in the current top level.

---
 rtl/audio_bridge_pkg.sv | 23 ++
 rtl/sample_fifo.sv | 53 +++++
 rtl/audio_stream_bridge.sv | 139 +++++++++++++
 tb/tb_audio_stream_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_bridge_pkg.sv
// Shared types and helpers for the audio stream bridge: FIFO entry and
// result-slot records sized for the widest legal configuration.
package audio_bridge_pkg;

    localparam int CNT_W    = 8;
    localparam int MAX_W    = 32;
    localparam int MAX_CH_W = 3;

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic [MAX_W-1:0]    data;
    } fifo_entry_t;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic             valid;
    } slot_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Registered synchronous FIFO (no fall-through); a push into a full FIFO is
// dropped unless a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    // Head reads as zero while empty so downstream sees clean outputs after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/audio_stream_bridge.sv
// Bridges I2S RX samples through an external processing engine to I2S TX,
// with per-channel result slots, full-resolution bypass and error counters.
module audio_stream_bridge
    import audio_bridge_pkg::*;
#(
    parameter int DATA_W        = 24,
    parameter int PROC_W        = 16,
    parameter int NUM_CH        = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int UNDERRUN_HOLD = 1,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              lmmi_clk_i,
    input  logic              reset_n_i,
    input  logic              rx_valid_i,
    input  logic [31:0]       rx_data_i,
    input  logic              tx_req_i,
    output logic [31:0]       tx_data_o,
    input  logic [NUM_CH-1:0] bypass_i,
    output logic              proc_valid_o,
    output logic [CH_W-1:0]   proc_ch_o,
    output logic [PROC_W-1:0] proc_data_o,
    input  logic              proc_ready_i,
    input  logic              res_valid_i,
    input  logic [CH_W-1:0]   res_ch_i,
    input  logic [PROC_W-1:0] res_data_i,
    output logic [CNT_W-1:0]  underrun_cnt_o,
    output logic [CNT_W-1:0]  overrun_cnt_o
);

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(NUM_CH-1)) ? '0 : ch + CH_W'(1);
    endfunction

    fifo_entry_t       push_entry;
    fifo_entry_t       head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              fifo_pop;
    logic [CH_W-1:0]   rx_ch;
    logic [CH_W-1:0]   tx_ch;
    logic [DATA_W-1:0] raw  [NUM_CH];
    slot_t             slot [NUM_CH];
    logic [31:0]       last [NUM_CH];
    logic [31:0]       tx_next;
    logic              tx_good;
    logic              tx_underrun;
    logic              res_wr;
    logic              slot_ovr;

    // Bits beyond the configured widths carry no information.
    logic [$bits(fifo_entry_t)-1:0] head_unused;
    logic [31:0]                    rx_unused;
    assign head_unused = head_entry;
    assign rx_unused   = rx_data_i;

    always_comb begin
        push_entry      = '0;
        push_entry.ch   = MAX_CH_W'(rx_ch);
        push_entry.data = MAX_W'(rx_data_i[DATA_W-1 -: PROC_W]);
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_rx_fifo (
        .clk   (lmmi_clk_i),
        .rst_n (reset_n_i),
        .push  (rx_valid_i),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign proc_valid_o = !fifo_empty;
    assign fifo_pop     = proc_valid_o && proc_ready_i;
    assign proc_ch_o    = head_entry.ch[CH_W-1:0];
    assign proc_data_o  = head_entry.data[PROC_W-1:0];

    // A result landing on a slot the TX side is consuming this cycle is not an overrun.
    assign res_wr   = res_valid_i && (int'(res_ch_i) < NUM_CH);
    assign slot_ovr = res_wr && slot[res_ch_i].valid && !(tx_req_i && tx_ch == res_ch_i);

    always_comb begin
        tx_next     = '0;
        tx_good     = 1'b0;
        tx_underrun = 1'b0;
        if (bypass_i[tx_ch]) begin
            tx_next = 32'(raw[tx_ch]);
        end else if (slot[tx_ch].valid) begin
            tx_next = slot[tx_ch].data << (DATA_W - PROC_W);
            tx_good = 1'b1;
        end else begin
            tx_underrun = 1'b1;
            tx_next     = (UNDERRUN_HOLD != 0) ? last[tx_ch] : '0;
        end
    end

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_ch          <= '0;
            tx_ch          <= '0;
            tx_data_o      <= '0;
            underrun_cnt_o <= '0;
            overrun_cnt_o  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                raw[i]  <= '0;
                slot[i] <= '0;
                last[i] <= '0;
            end
        end else begin
            if (rx_valid_i) begin
                raw[rx_ch] <= rx_data_i[DATA_W-1:0];
                rx_ch      <= next_ch(rx_ch);
            end
            if (tx_req_i) begin
                tx_data_o <= tx_next;
                tx_ch     <= next_ch(tx_ch);
                if (tx_good) last[tx_ch] <= tx_next;
            end
            // A new result wins over the TX clear, so it survives to the next frame.
            for (int i = 0; i < NUM_CH; i++) begin
                if (res_wr && res_ch_i == CH_W'(i))
                    slot[i] <= '{data: MAX_W'(res_data_i), valid: 1'b1};
                else if (tx_req_i && tx_ch == CH_W'(i))
                    slot[i].valid <= 1'b0;
            end
            if (tx_req_i && tx_underrun)
                underrun_cnt_o <= sat_inc(underrun_cnt_o);
            if (fifo_drop || slot_ovr)
                overrun_cnt_o <= sat_inc(overrun_cnt_o);
        end
    end

endmodule

// File: tb/tb_audio_stream_bridge.sv
// Directed bench for audio_stream_bridge: echo engine model, table-driven
// frames plus hand sequences for stall, underrun, overrun and reset cases.
module tb_audio_stream_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        tx_req;
    logic [1:0]  bypass;
    logic        ready;
    logic        echo_on;
    logic        man_res;
    logic        man_v;
    logic [0:0]  man_ch;
    logic [15:0] man_d;
    logic        res_valid;
    logic [0:0]  res_ch;
    logic [15:0] res_data;

    logic        eng_v  = 1'b0;
    logic [0:0]  eng_ch = '0;
    logic [15:0] eng_d  = '0;

    logic [31:0] tx_data,  tx_data0;
    logic        proc_valid, proc_valid0;
    logic [0:0]  proc_ch, proc_ch0;
    logic [15:0] proc_data, proc_data0;
    logic [7:0]  und, und0, ovr, ovr0;

    assign res_valid = man_res ? man_v  : eng_v;
    assign res_ch    = man_res ? man_ch : eng_ch;
    assign res_data  = man_res ? man_d  : eng_d;

    audio_stream_bridge #(.UNDERRUN_HOLD(1)) dut (
        .lmmi_clk_i(clk), .reset_n_i(reset_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_req_i(tx_req), .tx_data_o(tx_data), .bypass_i(bypass),
        .proc_valid_o(proc_valid), .proc_ch_o(proc_ch), .proc_data_o(proc_data),
        .proc_ready_i(ready), .res_valid_i(res_valid), .res_ch_i(res_ch), .res_data_i(res_data),
        .underrun_cnt_o(und), .overrun_cnt_o(ovr)
    );

    audio_stream_bridge #(.UNDERRUN_HOLD(0)) dut0 (
        .lmmi_clk_i(clk), .reset_n_i(reset_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_req_i(tx_req), .tx_data_o(tx_data0), .bypass_i(bypass),
        .proc_valid_o(proc_valid0), .proc_ch_o(proc_ch0), .proc_data_o(proc_data0),
        .proc_ready_i(ready), .res_valid_i(res_valid), .res_ch_i(res_ch), .res_data_i(res_data),
        .underrun_cnt_o(und0), .overrun_cnt_o(ovr0)
    );

    // Echo engine: result equals the accepted head sample, two cycles later.
    logic        pv0 = 1'b0, pv1 = 1'b0;
    logic [0:0]  pc0 = '0, pc1 = '0;
    logic [15:0] pd0 = '0, pd1 = '0;
    always begin
        @(posedge clk);
        #2;
        eng_v = pv1; eng_ch = pc1; eng_d = pd1;
        pv1 = pv0;   pc1 = pc0;    pd1 = pd0;
        pv0 = echo_on && ready && proc_valid;
        pc0 = proc_ch;
        pd0 = proc_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic do_rx(input logic [23:0] d);
        rx_valid = 1'b1;
        rx_data  = {8'hEE, d};
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic do_tx();
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(1);
    endtask

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [1:0]  byp;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{l: 24'h123456, r: 24'hFEDCBA, byp: 2'b00, el: 32'h00123400, er: 32'h00FEDC00};
        vecs[1] = '{l: 24'h0000AB, r: 24'hFEDCBA, byp: 2'b01, el: 32'h000000AB, er: 32'h00FEDC00};
        vecs[2] = '{l: 24'h800000, r: 24'h7FFFFF, byp: 2'b10, el: 32'h00800000, er: 32'h007FFFFF};
        vecs[3] = '{l: 24'hABCDEF, r: 24'h000001, byp: 2'b11, el: 32'h00ABCDEF, er: 32'h00000001};

        reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_req = 1'b0; bypass = '0;
        ready = 1'b0; echo_on = 1'b0; man_res = 1'b0; man_v = 1'b0; man_ch = '0; man_d = '0;
        #1;
        chk("reset tx_data", tx_data, 32'h0);
        chk("reset proc_valid", 32'(proc_valid), 32'h0);
        chk("reset proc_data", 32'(proc_data), 32'h0);
        chk("reset underrun", 32'(und), 32'h0);
        chk("reset overrun", 32'(ovr), 32'h0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(1);

        // Frames through the echo engine with various bypass masks
        echo_on = 1'b1; ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            do_rx(vecs[v].l);
            do_rx(vecs[v].r);
            wait_cyc(8);
            bypass = vecs[v].byp;
            do_tx();
            chk($sformatf("vec%0d L", v), tx_data, vecs[v].el);
            do_tx();
            chk($sformatf("vec%0d R", v), tx_data, vecs[v].er);
        end
        chk("table underrun", 32'(und), 32'h0);
        chk("table overrun", 32'(ovr), 32'h0);
        bypass = '0;

        // Engine stalled: FIFO overrun and ordering
        do_reset();
        echo_on = 1'b0; ready = 1'b0;
        for (int k = 0; k < 6; k++) do_rx(24'hA00000 + 24'(k) * 24'h010100);
        chk("stall proc_valid", 32'(proc_valid), 32'h1);
        chk("stall overrun", 32'(ovr), 32'h2);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fifo%0d ch", k), 32'(proc_ch), 32'(k % 2));
            chk($sformatf("fifo%0d data", k), 32'(proc_data), 32'(16'hA000 + 16'(k) * 16'h0101));
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
        chk("fifo drained", 32'(proc_valid), 32'h0);

        // Underrun hold versus zero
        do_reset();
        echo_on = 1'b1; ready = 1'b1;
        do_rx(24'h123456);
        wait_cyc(8);
        do_tx();
        chk("good L", tx_data, 32'h00123400);
        echo_on = 1'b0; ready = 1'b0;
        do_tx();
        chk("hold R", tx_data, 32'h0);
        chk("hold und1", 32'(und), 32'h1);
        do_tx();
        chk("hold L", tx_data, 32'h00123400);
        chk("hold und2", 32'(und), 32'h2);
        chk("zero L", tx_data0, 32'h0);
        do_tx();
        chk("hold R2", tx_data, 32'h0);
        chk("hold und3", 32'(und), 32'h3);
        chk("zero R2", tx_data0, 32'h0);
        chk("zero und3", 32'(und0), 32'h3);

        // Result and request collide on an empty slot
        do_reset();
        man_res = 1'b1;
        man_v = 1'b1; man_ch = 1'b0; man_d = 16'h4321; tx_req = 1'b1;
        @(negedge clk);
        man_v = 1'b0; tx_req = 1'b0;
        chk("collide out", tx_data, 32'h0);
        chk("collide und", 32'(und), 32'h1);
        chk("collide ovr", 32'(ovr), 32'h0);
        do_tx();
        chk("collide R und", 32'(und), 32'h2);
        do_tx();
        chk("collide replay", tx_data, 32'h00432100);
        chk("collide und held", 32'(und), 32'h2);
        for (int k = 0; k < 300; k++) do_tx();
        chk("und saturate", 32'(und), 32'hFF);
        chk("und0 saturate", 32'(und0), 32'hFF);
        man_v = 1'b1; man_ch = 1'b1; man_d = 16'h1111;
        @(negedge clk);
        man_d = 16'h2222;
        @(negedge clk);
        man_v = 1'b0;
        chk("slot overwrite ovr", 32'(ovr), 32'h1);
        do_tx();
        chk("slot overwrite data", tx_data, 32'h00222200);
        man_res = 1'b0;

        // Asynchronous reset mid-frame
        do_reset();
        do_rx(24'h654321);
        do_rx(24'h111111);
        do_rx(24'h222222);
        do_tx();
        bypass = 2'b11;
        do_tx();
        chk("pre-reset tx", tx_data, 32'h00111111);
        chk("pre-reset und", 32'(und), 32'h1);
        chk("pre-reset valid", 32'(proc_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async tx_data", tx_data, 32'h0);
        chk("async und", 32'(und), 32'h0);
        chk("async proc_valid", 32'(proc_valid), 32'h0);
        chk("async proc_data", 32'(proc_data), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bypass = '0;
        do_rx(24'h0A0B0C);
        chk("post-reset ch", 32'(proc_ch), 32'h0);
        chk("post-reset data", 32'(proc_data), 32'h0A0B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
